// File: rtl/mini_cpu_prog_loader.sv
// rtl/mini_cpu_prog_loader.sv - byte-stream program loader for the mini_cpu instruction memory
//
// Purpose: accepts a program over a valid/ready stream, writes it into
//   instruction memory words 0..DEPTH-1, pads the unused tail with PAD_WORD,
//   and holds the CPU in reset until the whole image has been written.
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              one-cycle pulse that begins a (re)load
//   s_valid/s_ready    stream handshake; s_data is the word, s_last marks the final one
//   mem_we/addr/wdata  instruction memory write port (one cycle per word)
//   cpu_rst_n          active-low reset to the CPU, released after the image is complete
//   load_done          image written and CPU running
//   load_err           DEPTH words arrived without s_last
module mini_cpu_prog_loader #(
    parameter int                 ADDR_W   = 3,
    parameter int                 DATA_W   = 8,
    parameter logic [DATA_W-1:0]  PAD_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst_n,
    output logic              load_done,
    output logic              load_err
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    // idx carries one extra bit so a full count is distinguishable from zero.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FILL,
        DONE,
        RUN,
        ERR
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W:0]     idx;
    logic [ADDR_W:0]     idx_nxt;
    logic                s_ready_nxt;
    logic                mem_we_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic [DATA_W-1:0]   mem_wdata_nxt;
    logic                cpu_rst_n_nxt;
    logic                load_done_nxt;
    logic                load_err_nxt;
    logic                xfer;

    // s_ready is a register, so a transfer is always judged on the value
    // the upstream side saw during the cycle.
    assign xfer = s_valid & s_ready;

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        cpu_rst_n_nxt = cpu_rst_n;
        load_done_nxt = load_done;
        load_err_nxt  = load_err;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    idx_nxt   = '0;
                end
            end

            LOAD: begin
                if (xfer) begin
                    mem_we_nxt    = 1'b1;
                    mem_addr_nxt  = idx[ADDR_W-1:0];
                    mem_wdata_nxt = s_data;
                    idx_nxt       = idx + IDX_ONE;
                    if (idx == LAST_IDX) begin
                        if (s_last) begin
                            state_nxt = DONE;
                        end else begin
                            // Memory is full but the program has not ended;
                            // the word is still written so the image is inspectable.
                            state_nxt    = ERR;
                            load_err_nxt = 1'b1;
                        end
                    end else if (s_last) begin
                        state_nxt = FILL;
                    end
                end
            end

            FILL: begin
                mem_we_nxt    = 1'b1;
                mem_addr_nxt  = idx[ADDR_W-1:0];
                mem_wdata_nxt = PAD_WORD;
                idx_nxt       = idx + IDX_ONE;
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end

            DONE: begin
                // DONE is entered on the edge that issues the final write, so
                // mem_we is still high on the first cycle here. Waiting for it
                // to drop guarantees the memory has taken the last word before
                // the CPU leaves reset.
                if (!mem_we) begin
                    state_nxt     = RUN;
                    cpu_rst_n_nxt = 1'b1;
                    load_done_nxt = 1'b1;
                end
            end

            RUN: begin
                if (start) begin
                    state_nxt     = LOAD;
                    idx_nxt       = '0;
                    cpu_rst_n_nxt = 1'b0;
                    load_done_nxt = 1'b0;
                end
            end

            ERR: begin
                if (start) begin
                    state_nxt    = LOAD;
                    idx_nxt      = '0;
                    load_err_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt     = IDLE;
                idx_nxt       = '0;
                cpu_rst_n_nxt = 1'b0;
                load_done_nxt = 1'b0;
                load_err_nxt  = 1'b0;
            end
        endcase

        // Ready is registered from the next state, so it falls on the same
        // edge that accepts the final word and no extra word slips in.
        s_ready_nxt = (state_nxt == LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            s_ready   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst_n <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            s_ready   <= s_ready_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            cpu_rst_n <= cpu_rst_n_nxt;
            load_done <= load_done_nxt;
            load_err  <= load_err_nxt;
        end
    end

endmodule

// File: tb/tb_mini_cpu_prog_loader.sv
// tb/tb_mini_cpu_prog_loader.sv - self-checking bench for mini_cpu_prog_loader
module tb_mini_cpu_prog_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;
    logic       mem_we;
    logic [2:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_rst_n;
    logic       load_done;
    logic       load_err;

    mini_cpu_prog_loader #(
        .ADDR_W   (3),
        .DATA_W   (8),
        .PAD_WORD (8'h00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instruction memory model plus per-address write counters.
    logic [7:0] model_mem [8];
    int         wr_cnt [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int         base [8];

    always @(posedge clk) begin
        if (mem_we) begin
            model_mem[mem_addr] <= mem_wdata;
            wr_cnt[mem_addr]    <= wr_cnt[mem_addr] + 1;
        end
    end

    typedef struct {
        logic       start;
        logic       valid;
        logic [7:0] data;
        logic       last;
        logic [15:0] exp;
    } vec_t;

    vec_t       tbl [12];
    logic [7:0] p1 [8] = '{8'h03, 8'h05, 8'h42, 8'h86, 8'hCD, 8'h87, 8'h43, 8'h01};
    logic [7:0] p2 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] img [8];

    function automatic logic [15:0] mk(logic r, logic w, logic [2:0] a, logic [7:0] d,
                                       logic c, logic dn, logic e);
        return {r, w, a, d, c, dn, e};
    endfunction

    function automatic logic [15:0] outs();
        return {s_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, load_done, load_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        for (int a = 0; a < 8; a++) base[a] = wr_cnt[a];
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offer one word until accepted, then idle for 'gaps' cycles with junk data.
    task automatic send(input logic [7:0] word, input logic last, input int gaps);
        logic x;
        int   tries;
        s_valid = 1'b1;
        s_data  = word;
        s_last  = last;
        tries   = 0;
        do begin
            x = s_ready;
            tick();
            tries++;
        end while (!x && tries < 20);
        if (!x) check("xfer_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'hEE;
        repeat (gaps) tick();
    endtask

    // Called just after the last-transfer edge: counts edges until cpu_rst_n
    // rises and records on which of those edges a pad write appeared.
    task automatic wait_release(input string name, input int k, input int exp_edges);
        int          n;
        logic [31:0] pat;
        n   = 0;
        pat = '0;
        while (!cpu_rst_n && n < 30) begin
            tick();
            if (mem_we) pat[n] = 1'b1;
            n++;
        end
        check({name, "_release_edges"}, 32'(n), 32'(exp_edges));
        check({name, "_pad_pattern"}, pat, (32'd1 << k) - 32'd1);
        check({name, "_done"}, {31'd0, load_done}, 32'd1);
    endtask

    task automatic check_image(input string name, input logic [7:0] exp_img [8]);
        for (int a = 0; a < 8; a++) begin
            check($sformatf("%s_mem%0d", name, a), 32'(model_mem[a]), 32'(exp_img[a]));
            check($sformatf("%s_wrcnt%0d", name, a), 32'(wr_cnt[a] - base[a]), 32'd1);
        end
    endtask

    initial begin
        // T1 vectors, expectations as seen just after each edge.
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0)};
        for (int i = 0; i < 8; i++)
            tbl[i+1] = '{1'b0, 1'b1, p1[i], (i == 7),
                         mk((i != 7), 1'b1, 3'(i), p1[i], 1'b0, 1'b0, 1'b0)};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, mk(1'b0, 1'b0, 3'd7, 8'h01, 1'b0, 1'b0, 1'b0)};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, mk(1'b0, 1'b0, 3'd7, 8'h01, 1'b1, 1'b1, 1'b0)};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, mk(1'b0, 1'b0, 3'd7, 8'h01, 1'b1, 1'b1, 1'b0)};

        // Reset state
        repeat (2) tick();
        check("reset_outputs", 32'(outs()), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_outputs", 32'(outs()), 32'd0);

        // T1 full load, table driven
        snap();
        for (int i = 0; i < 12; i++) begin
            start   = tbl[i].start;
            s_valid = tbl[i].valid;
            s_data  = tbl[i].data;
            s_last  = tbl[i].last;
            tick();
            check($sformatf("t1_vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end
        start   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        check_image("t1", p1);

        // T5 reload from RUN with a one-word program
        pulse_start();
        check("t5_start_edge", {29'd0, cpu_rst_n, load_done, s_ready}, 32'b001);
        snap();
        send(8'h00, 1'b1, 0);
        wait_release("t5", 7, 9);
        for (int a = 0; a < 8; a++) img[a] = 8'h00;
        check_image("t5", img);

        // T2 short program, five pad words
        pulse_start();
        snap();
        send(8'h03, 1'b0, 0);
        send(8'h05, 1'b0, 0);
        send(8'h42, 1'b1, 0);
        wait_release("t2", 5, 7);
        img = '{8'h03, 8'h05, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_image("t2", img);

        // T3 gaps between words
        pulse_start();
        snap();
        for (int i = 0; i < 8; i++) send(p1[i], (i == 7), (i == 7) ? 0 : 2);
        wait_release("t3", 0, 2);
        check_image("t3", p1);

        // T4 overflow
        pulse_start();
        snap();
        for (int i = 0; i < 8; i++) send(p2[i], 1'b0, 0);
        check("t4_err_state", {28'd0, s_ready, cpu_rst_n, load_err, load_done}, 32'b0010);
        s_valid = 1'b1;
        s_data  = 8'h99;
        repeat (4) tick();
        check("t4_no_accept", {31'd0, s_ready}, 32'd0);
        s_valid = 1'b0;
        check_image("t4", p2);
        pulse_start();
        check("t4_start_clears", {30'd0, load_err, s_ready}, 32'b01);

        // T6 asynchronous reset mid-load (loader is in LOAD now)
        snap();
        send(8'hA1, 1'b0, 0);
        send(8'hA2, 1'b0, 0);
        send(8'hA3, 1'b0, 1);
        #2 rst_n = 1'b0;
        #1 check("t6_async_reset", 32'(outs()), 32'd0);
        s_valid = 1'b1;
        repeat (3) tick();
        check("t6_held_in_reset", 32'(outs()), 32'd0);
        for (int a = 0; a < 8; a++)
            check($sformatf("t6_partial_wr%0d", a), 32'(wr_cnt[a] - base[a]), (a < 3) ? 32'd1 : 32'd0);
        s_valid = 1'b0;
        rst_n   = 1'b1;
        tick();
        check("t6_idle_after_reset", 32'(outs()), 32'd0);
        pulse_start();
        send(8'h5A, 1'b1, 0);
        check("t6_restart_addr", {20'd0, mem_we, mem_addr, mem_wdata}, {20'd0, 1'b1, 3'd0, 8'h5A});
        wait_release("t6", 7, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
